enemy_spawn_scheduler: RTL and testbench

- Decides when each of three enemy classes (small/medium/boss) spawns and which free slot it uses.
- Drives the trigger/trigger-index inputs of the per-class enemy datapath instances in place of their free-running trigger counters.
- Spawn interval per class shrinks with the game level.
- One spawn per cycle, arbitrated round-robin among classes with a pending spawn.

---
 rtl/enemy_spawn_scheduler.sv | 160 ++++++++++++++++
 tb/tb_enemy_spawn_scheduler.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_spawn_scheduler.sv
// Spawn scheduler for three enemy classes: per-class interval timers, free-slot search
// and round-robin arbitration. The result is one registered spawn pulse per cycle at most.
module enemy_spawn_scheduler #(
  parameter int unsigned SLOTS_C0    = 10,
  parameter int unsigned SLOTS_C1    = 4,
  parameter int unsigned SLOTS_C2    = 2,
  parameter int unsigned INTERVAL_C0 = 20000000,
  parameter int unsigned INTERVAL_C1 = 60000000,
  parameter int unsigned INTERVAL_C2 = 250000000,
  parameter int unsigned CNT_BIT_LEN = 28,
  parameter int unsigned IDX_BIT_LEN = 4
) (
  input  logic                   clk_run,
  input  logic                   rst_n,
  input  logic                   en_i,
  input  logic [1:0]             level_i,
  input  logic [SLOTS_C0-1:0]    busy_c0_i,
  input  logic [SLOTS_C1-1:0]    busy_c1_i,
  input  logic [SLOTS_C2-1:0]    busy_c2_i,
  output logic                   spawn_o,
  output logic [1:0]             spawn_class_o,
  output logic [IDX_BIT_LEN-1:0] spawn_idx_o,
  output logic [7:0]             drop_cnt_o
);

  typedef logic [CNT_BIT_LEN-1:0] cnt_t;

  localparam cnt_t IntvC0 = cnt_t'(INTERVAL_C0);
  localparam cnt_t IntvC1 = cnt_t'(INTERVAL_C1);
  localparam cnt_t IntvC2 = cnt_t'(INTERVAL_C2);

  localparam logic [15:0] ValidC0 = 16'((32'd1 << SLOTS_C0) - 32'd1);
  localparam logic [15:0] ValidC1 = 16'((32'd1 << SLOTS_C1) - 32'd1);
  localparam logic [15:0] ValidC2 = 16'((32'd1 << SLOTS_C2) - 32'd1);

  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // State
  cnt_t [2:0]             cnt_q, cnt_d;
  logic [2:0]             pend_q, pend_d;
  logic [2:0][15:0]       rsv_q, rsv_d;
  logic [1:0]             rr_q, rr_d;
  logic                   spawn_q, spawn_d;
  logic [1:0]             class_q, class_d;
  logic [IDX_BIT_LEN-1:0] idx_q, idx_d;
  logic [7:0]             drop_q, drop_d;

  // Per-class combinational view
  cnt_t [2:0]       intv;
  cnt_t [2:0]       lim;
  logic [2:0][15:0] busy_pad;
  logic [2:0][15:0] valid;
  logic [2:0][15:0] free;
  logic [2:0][3:0]  slot;
  logic [2:0]       avail;
  logic [2:0]       tick;

  // Arbitration
  logic [2:0] grant;
  logic [1:0] gnt_cls;
  logic       found;
  logic [1:0] cand;

  logic [2:0] drop_vec;
  logic [8:0] drop_sum;

  always_comb begin
    intv     = {IntvC2, IntvC1, IntvC0};
    valid    = {ValidC2, ValidC1, ValidC0};
    busy_pad = {16'(busy_c2_i), 16'(busy_c1_i), 16'(busy_c0_i)};
    for (int c = 0; c < 3; c++) begin
      free[c]  = ~busy_pad[c] & ~rsv_q[c] & valid[c];
      slot[c]  = lowest_idx(free[c]);
      avail[c] = pend_q[c] & (|free[c]);
      // Level halves the interval per step; sampled live on every compare.
      lim[c]   = (intv[c] >> level_i) - cnt_t'(1);
      tick[c]  = en_i & (cnt_q[c] == lim[c]);
    end
  end

  always_comb begin
    grant   = '0;
    gnt_cls = '0;
    found   = 1'b0;
    cand    = '0;
    if (en_i) begin
      for (int k = 0; k < 3; k++) begin
        cand = 2'((int'(rr_q) + k) % 3);
        if (!found && avail[cand]) begin
          found       = 1'b1;
          grant[cand] = 1'b1;
          gnt_cls     = cand;
        end
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    rsv_d    = '0;
    rr_d     = rr_q;
    spawn_d  = found;
    class_d  = class_q;
    idx_d    = idx_q;
    drop_vec = '0;
    for (int c = 0; c < 3; c++) begin
      if (en_i) begin
        cnt_d[c]  = tick[c] ? '0 : cnt_q[c] + cnt_t'(1);
        // A grant consumes the old request; a coincident tick starts a new one.
        pend_d[c] = grant[c] ? tick[c] : (pend_q[c] | tick[c]);
      end
      drop_vec[c] = tick[c] & pend_q[c] & ~grant[c];
      // Hold the granted slot off for one cycle while its busy flag catches up.
      if (grant[c]) rsv_d[c] = 16'(1) << slot[c];
    end
    if (found) begin
      class_d = gnt_cls;
      idx_d   = IDX_BIT_LEN'(slot[gnt_cls]);
      rr_d    = (gnt_cls == 2'd2) ? 2'd0 : gnt_cls + 2'd1;
    end
    drop_sum = {1'b0, drop_q} + 9'(drop_vec[0]) + 9'(drop_vec[1]) + 9'(drop_vec[2]);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk_run) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pend_q  <= '0;
      rsv_q   <= '0;
      rr_q    <= '0;
      spawn_q <= 1'b0;
      class_q <= '0;
      idx_q   <= '0;
      drop_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      rsv_q   <= rsv_d;
      rr_q    <= rr_d;
      spawn_q <= spawn_d;
      class_q <= class_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  assign spawn_o       = spawn_q;
  assign spawn_class_o = class_q;
  assign spawn_idx_o   = idx_q;
  assign drop_cnt_o    = drop_q;

endmodule

// File: tb/tb_enemy_spawn_scheduler.sv
// Bench for enemy_spawn_scheduler: directed scenarios plus a randomized run, all outputs
// compared every cycle against a behavioural model built from the scheduling rules.
module tb_enemy_spawn_scheduler;

  localparam int unsigned S0 = 10;
  localparam int unsigned S1 = 4;
  localparam int unsigned S2 = 2;
  localparam int unsigned I0 = 8;
  localparam int unsigned I1 = 48;
  localparam int unsigned I2 = 96;
  localparam int unsigned CntW = 8;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [1:0]    level;
  logic [S0-1:0] busy_c0;
  logic [S1-1:0] busy_c1;
  logic [S2-1:0] busy_c2;
  logic          spawn_o;
  logic [1:0]    spawn_class_o;
  logic [3:0]    spawn_idx_o;
  logic [7:0]    drop_cnt_o;

  int tests = 0;
  int fails = 0;

  enemy_spawn_scheduler #(
    .SLOTS_C0   (S0),
    .SLOTS_C1   (S1),
    .SLOTS_C2   (S2),
    .INTERVAL_C0(I0),
    .INTERVAL_C1(I1),
    .INTERVAL_C2(I2),
    .CNT_BIT_LEN(CntW),
    .IDX_BIT_LEN(4)
  ) u_dut (
    .clk_run      (clk),
    .rst_n        (rst_n),
    .en_i         (en),
    .level_i      (level),
    .busy_c0_i    (busy_c0),
    .busy_c1_i    (busy_c1),
    .busy_c2_i    (busy_c2),
    .spawn_o      (spawn_o),
    .spawn_class_o(spawn_class_o),
    .spawn_idx_o  (spawn_idx_o),
    .drop_cnt_o   (drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state; reserved slot is -1 when none.
  int m_cnt[3];
  int m_pend[3];
  int m_rsv[3];
  int m_rr;
  int m_spawn;
  int m_cls;
  int m_idx;
  int m_drop;

  function automatic int slots_of(input int c);
    return (c == 0) ? S0 : (c == 1) ? S1 : S2;
  endfunction

  function automatic int intv_of(input int c);
    return (c == 0) ? I0 : (c == 1) ? I1 : I2;
  endfunction

  function automatic bit busy_bit(input int c, input int s);
    if (c == 0) return busy_c0[s];
    if (c == 1) return busy_c1[s];
    return busy_c2[s];
  endfunction

  task automatic model_step();
    int first[3];
    bit avail[3];
    bit tick;
    int g;
    int nd;
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin
        m_cnt[c] = 0; m_pend[c] = 0; m_rsv[c] = -1;
      end
      m_rr = 0; m_spawn = 0; m_cls = 0; m_idx = 0; m_drop = 0;
      return;
    end
    for (int c = 0; c < 3; c++) begin
      first[c] = -1;
      for (int s = 0; s < slots_of(c); s++) begin
        if (first[c] < 0 && !busy_bit(c, s) && m_rsv[c] != s) first[c] = s;
      end
      avail[c] = (m_pend[c] != 0) && (first[c] >= 0);
    end
    g = -1;
    if (en) begin
      for (int k = 0; k < 3; k++) begin
        if (g < 0 && avail[(m_rr + k) % 3]) g = (m_rr + k) % 3;
      end
    end
    nd = 0;
    for (int c = 0; c < 3; c++) begin
      tick = en && (m_cnt[c] == (intv_of(c) >> level) - 1);
      if (en) m_cnt[c] = tick ? 0 : (m_cnt[c] + 1) % (1 << CntW);
      if (tick && m_pend[c] != 0 && g != c) nd++;
      if (en) m_pend[c] = (g == c) ? int'(tick) : int'(m_pend[c] != 0 || tick);
      m_rsv[c] = (g == c) ? first[c] : -1;
    end
    m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
    m_spawn = (g >= 0);
    if (g >= 0) begin
      m_cls = g;
      m_idx = first[g];
      m_rr  = (g + 1) % 3;
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("spawn", int'(spawn_o), m_spawn);
    check("class", int'(spawn_class_o), m_cls);
    check("idx", int'(spawn_idx_o), m_idx);
    check("drop", int'(drop_cnt_o), m_drop);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Runs up to max_cyc cycles until a spawn is visible; waited = cycles consumed.
  task automatic wait_spawn(input int max_cyc, output bit seen, output int waited);
    seen = 1'b0;
    waited = 0;
    while (!seen && waited < max_cyc) begin
      cycle();
      waited++;
      seen = spawn_o;
    end
  endtask

  bit seen;
  int waited;
  int n;

  initial begin
    rst_n = 1'b0; en = 1'b0; level = 2'd0;
    busy_c0 = '0; busy_c1 = '0; busy_c2 = '0;

    // Reset values
    do_reset();
    check("rst_spawn", int'(spawn_o), 0);
    check("rst_class", int'(spawn_class_o), 0);
    check("rst_idx", int'(spawn_idx_o), 0);
    check("rst_drop", int'(drop_cnt_o), 0);

    // Level 0 cadence, then switch to level 2 right after a spawn
    en = 1'b1; busy_c1 = '1; busy_c2 = '1;
    repeat (30) cycle();
    wait_spawn(20, seen, waited);
    check("lvl_seen", int'(seen), 1);
    level = 2'd2;
    repeat (4) cycle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (spawn_o && spawn_class_o == 2'd0) n++;
    end
    check("lvl2_count", n, 10);

    // Back-to-back ticks with slots 0..2 busy: reserve forces 3 then 4
    level = 2'd3; busy_c0 = 10'b0000000111;
    do_reset();
    wait_spawn(10, seen, waited);
    check("b2b_seen", int'(seen), 1);
    check("b2b_idx0", int'(spawn_idx_o), 3);
    cycle();
    check("b2b_spawn1", int'(spawn_o), 1);
    check("b2b_idx1", int'(spawn_idx_o), 4);

    // Full class 0: pending held, two drops, then slot 5 frees
    level = 2'd0; busy_c0 = '1;
    do_reset();
    n = 0;
    for (int i = 0; i < 26; i++) begin
      cycle();
      if (spawn_o) n++;
    end
    check("full_nospawn", n, 0);
    check("full_drop", int'(drop_cnt_o), 2);
    busy_c0 = 10'b1111011111;
    wait_spawn(4, seen, waited);
    check("free_seen", int'(seen), 1);
    check("free_idx", int'(spawn_idx_o), 5);
    check("free_class", int'(spawn_class_o), 0);

    // All three classes pending together
    busy_c0 = '1; busy_c1 = '1; busy_c2 = '1;
    do_reset();
    repeat (100) cycle();
    busy_c0 = '0; busy_c1 = '0; busy_c2 = '0;
    wait_spawn(4, seen, waited);
    check("rr_seen", int'(seen), 1);
    check("rr_c0", int'(spawn_class_o), 0);
    cycle();
    check("rr_c1", int'(spawn_class_o), 1);
    cycle();
    check("rr_c2", int'(spawn_class_o), 2);

    // Pause mid-interval
    busy_c1 = '1; busy_c2 = '1;
    do_reset();
    repeat (3) cycle();
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (spawn_o) n++;
    end
    check("pause_nospawn", n, 0);
    en = 1'b1;
    wait_spawn(20, seen, waited);
    check("pause_seen", int'(seen), 1);
    check("pause_resume", waited, I0 - 3 + 1);

    // Reset discards a held pending request
    busy_c0 = '1;
    do_reset();
    repeat (10) cycle();
    do_reset();
    busy_c0 = '0;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (spawn_o) n++;
    end
    check("rstpend_nospawn", n, 0);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) level = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        busy_c0 = 10'($urandom) & 10'($urandom) & 10'($urandom);
        busy_c1 = 4'($urandom) & 4'($urandom);
        busy_c2 = ($urandom_range(0, 4) == 0) ? 2'b11 : 2'($urandom);
      end
      if ($urandom_range(0, 49) == 0) busy_c0 = '1;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
